dsp_div_signed_seq: RTL and testbench

Iterative signed divider, the inverse of the signed DSP multiplier datapath. Takes the 38-bit signed product-width value and an 18-bit signed divisor, and returns the quotient and remainder one quotient bit per clock. It uses valid/ready handshakes on both sides. It serves as the recovery/check path in the DSP arithmetic test designs: a dividend P = A*B divided by B must return A with remainder 0.

---
 rtl/dsp_div_signed_seq.sv | 149 ++++++++++++++
 tb/tb_dsp_div_signed_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_div_signed_seq.sv
// dsp_div_signed_seq
// Sequential signed divider. It produces one quotient bit per clock using
// restoring shift-subtract on operand magnitudes, then applies the signs.
// The arithmetic matches signed '/' and '%': the quotient truncates toward
// zero and the remainder takes the sign of the dividend.
//
// Ports
//   clk, reset    single clock; synchronous active-high reset
//   in_valid      operands present
//   in_ready      ready to accept an operation (high only in IDLE)
//   dividend      DIVIDEND_W-bit signed dividend
//   divisor       DIVISOR_W-bit signed divisor
//   out_valid     result present; held until out_ready
//   out_ready     consumer takes the result
//   quotient      DIVIDEND_W-bit signed quotient (all ones on divide by zero)
//   remainder     DIVISOR_W-bit signed remainder
//   div_by_zero   divisor was zero for this result
//   overflow      -2^(DIVIDEND_W-1) / -1; the quotient wraps
module dsp_div_signed_seq #(
  parameter int DIVIDEND_W = 38,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CW = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  // Holds the dividend magnitude, which shifts out at the top. Quotient bits
  // shift in at the bottom, so the register holds the unsigned quotient
  // after the last CALC cycle.
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W:0]    dvs_mag;
  logic [DIVISOR_W-1:0]  prem;
  logic                  neg_q, neg_r, ovf_c;

  logic                  accept;
  logic                  dvs_zero;
  logic [DIVIDEND_W-1:0] dvd_abs;
  logic [DIVISOR_W:0]    dvs_ext, dvs_abs;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W-1:0]  diff;
  logic                  fits;

  assign accept   = in_valid && in_ready;
  assign dvs_zero = (divisor == '0);
  assign dvd_abs  = dividend[DIVIDEND_W-1] ? -dividend : dividend;
  assign dvs_ext  = {divisor[DIVISOR_W-1], divisor};
  assign dvs_abs  = dvs_ext[DIVISOR_W] ? -dvs_ext : dvs_ext;

  // The partial remainder is always below |divisor| <= 2^(DIVISOR_W-1), so the
  // shifted trial value fits in DIVISOR_W+1 bits. A successful subtraction
  // gives a result below 2^(DIVISOR_W-1). Computing it modulo 2^DIVISOR_W
  // is therefore exact.
  assign trial = {prem, dvd_q[DIVIDEND_W-1]};
  assign fits  = (trial >= dvs_mag);
  assign diff  = trial[DIVISOR_W-1:0] - dvs_mag[DIVISOR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nx = dvs_zero ? DONE : CALC;
      end
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ovf_c       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dvd_q   <= dvd_abs;
          dvs_mag <= dvs_abs;
          prem    <= '0;
          cnt     <= CW'(DIVIDEND_W - 1);
          neg_q   <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          neg_r   <= dividend[DIVIDEND_W-1];
          ovf_c   <= (dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (divisor == '1);
          if (dvs_zero) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end
        end
        CALC: begin
          prem  <= fits ? diff : trial[DIVISOR_W-1:0];
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], fits};
          cnt   <= cnt - 1'b1;
        end
        FIX: begin
          quotient    <= neg_q ? -dvd_q : dvd_q;
          remainder   <= neg_r ? -prem : prem;
          overflow    <= ovf_c;
          div_by_zero <= 1'b0;
        end
        DONE: if (out_ready) begin
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_div_signed_seq.sv
// Testbench for dsp_div_signed_seq.
// The stimulus process pushes each expected result into a scoreboard queue.
// The monitor process pops an entry and compares it whenever a result
// handshake occurs. It also checks the latency of every result.
module tb_dsp_div_signed_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [37:0] dividend;
  logic [17:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] quotient;
  logic [17:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  dsp_div_signed_seq #(.DIVIDEND_W(38), .DIVISOR_W(18)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [37:0] q;
    logic [17:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: plain signed 64-bit division, truncated to port widths.
  function automatic exp_t ref_div(input logic [37:0] a, input logic [17:0] b);
    exp_t   e;
    longint da, db, qe, re;
    da = longint'($signed(a));
    db = longint'($signed(b));
    e.acc = 0;
    if (db == 0) begin
      e.q = '1; e.r = '0; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 1;
    end else begin
      qe = da / db;
      re = da % db;
      e.q = qe[37:0];
      e.r = re[17:0];
      e.dbz = 1'b0;
      e.ovf = (qe > 64'sd137438953471);
      e.lat = 40;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [37:0] q, input logic [17:0] r,
                              input logic dbz, input logic ovf, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Issue one operation. When use_exp is set, expect e; otherwise use the model.
  task automatic issue(input logic [37:0] a, input logic [17:0] b,
                       input bit use_exp, input exp_t e, input bit push);
    int   n;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1; dividend = a; divisor = b;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = 18'($urandom);
    if (push) begin
      x = use_exp ? e : ref_div(a, b);
      x.acc = cyc;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor
  initial begin
    bit   prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          if (!prev_ov) chk("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          if (!prev_ov) chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
          if (out_ready) begin
            e = sb.pop_front();
            chk("quotient", 64'(quotient), 64'(e.q));
            chk("remainder", 64'(remainder), 64'(e.r));
            chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            chk("overflow", 64'(overflow), 64'(e.ovf));
          end
        end
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        nx;
    logic [17:0] b;
    logic [37:0] a;
    logic [37:0] hq;
    logic [17:0] hr;
    logic        hd, ho;
    int          n;
    nx = mk('0, '0, 1'b0, 1'b0, 0);

    // Reset held three cycles with in_valid asserted
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    dividend = 38'd100; divisor = 18'd3;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_quotient", 64'(quotient), 64'd0);
      chk("rst_remainder", 64'(remainder), 64'd0);
      chk("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed cases with constant expectations
    issue(-38'sd555, -18'sd5, 1, mk(38'd111, 18'd0, 0, 0, 40), 1);
    issue(-38'sd7, 18'sd2, 1, mk(38'h3F_FFFF_FFFD, 18'h3FFFF, 0, 0, 40), 1);
    issue(38'sd7, -18'sd2, 1, mk(38'h3F_FFFF_FFFD, 18'd1, 0, 0, 40), 1);
    issue(-38'sd7, -18'sd2, 1, mk(38'd3, 18'h3FFFF, 0, 0, 40), 1);
    issue(38'd0, 18'h20000, 1, mk(38'd0, 18'd0, 0, 0, 40), 1);
    issue(38'd1234, 18'd0, 1, mk(38'h3F_FFFF_FFFF, 18'd0, 1, 0, 1), 1);
    issue(38'h20_0000_0000, 18'h3FFFF, 1, mk(38'h20_0000_0000, 18'd0, 0, 1, 40), 1);
    issue(38'h1F_FFFF_FFFF, 18'h20000, 1, mk(38'h3F_FFF0_0001, 18'd131071, 0, 0, 40), 1);
    drain();

    // Recovery path: (111*B)/B returns 111 with remainder 0
    for (int i = 0; i < 200; i++) begin
      b = 18'($urandom);
      if (b == '0) b = 18'd1;
      a = 38'(longint'(111) * longint'($signed(b)));
      issue(a, b, 1, mk(38'd111, 18'd0, 0, 0, 40), 1);
    end
    drain();

    // Fully random operands against the model
    for (int i = 0; i < 80; i++) begin
      a = {$urandom, $urandom};
      case (i % 4)
        0: b = 18'($urandom);
        1: b = 18'($urandom_range(1, 15));
        2: b = -18'($urandom_range(1, 15));
        default: b = (i % 8 == 3) ? 18'h20000 : 18'd0;
      endcase
      issue(a, b, 0, nx, 1);
    end
    drain();

    // Backpressure: result must hold and new requests must be ignored
    @(negedge clk);
    out_ready = 1'b0;
    issue(-38'sd1000, 18'sd7, 0, nx, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
    hq = quotient; hr = remainder; hd = div_by_zero; ho = overflow;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; dividend = {$urandom, $urandom}; divisor = 18'($urandom);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_q", 64'(quotient), 64'(hq));
      chk("bp_hold_r", 64'(remainder), 64'(hr));
      chk("bp_hold_flags", 64'({div_by_zero, overflow}), 64'({hd, ho}));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    drain();

    // Reset during CALC abandons the operation
    issue(38'd999999, 18'd3, 0, nx, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (45) @(negedge clk);
    chk("abort_no_result", 64'(out_valid), 64'd0);
    issue(-38'sd123456789, 18'sd1000, 0, nx, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
